// File: rtl/rx_word_sequencer.sv
// Receive-side write sequencer: pairs MAC bytes into 16-bit words and loads them
// into the receive register bank, deferring to CPU reads and flagging overrun.
module rx_word_sequencer #(
    parameter int NWORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              frm_end,
    input  logic              frm_abort,
    input  logic              cpu_busy,
    output logic [7:0]        wr_hi,
    output logic [7:0]        wr_lo,
    output logic [NWORDS-1:0] wr_en,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [4:0]        words
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX_HI = 2'd1,
        RX_LO = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state_r, state_n, eff_s;
    logic [7:0] hi_r, hi_n, eff_hi_s;
    logic [4:0] idx_r, idx_n;
    logic       pend_v_r, pend_v_n;
    logic [7:0] pend_hi_r, pend_hi_n, pend_lo_r, pend_lo_n;
    logic [4:0] pend_idx_r, pend_idx_n;
    logic [4:0] words_r, words_n;
    logic       overrun_r, overrun_n, done_r, done_n;
    logic       fire_s, new_v_s;
    logic [7:0] new_hi_s, new_lo_s;

    assign fire_s = pend_v_r & ~cpu_busy;

    // Load enable for the pending word, released only while the CPU is off the bank.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NWORDS; i++) begin
            wr_en[i] = fire_s && (pend_idx_r == 5'(i));
        end
    end

    // Next-state: abort beats start beats byte/end; a byte is consumed before an end.
    always_comb begin
        eff_s      = state_r;
        eff_hi_s   = hi_r;
        new_v_s    = 1'b0;
        new_hi_s   = 8'h00;
        new_lo_s   = 8'h00;
        state_n    = state_r;
        hi_n       = hi_r;
        idx_n      = idx_r;
        pend_v_n   = pend_v_r & ~fire_s;
        pend_hi_n  = pend_hi_r;
        pend_lo_n  = pend_lo_r;
        pend_idx_n = pend_idx_r;
        words_n    = words_r + {4'd0, fire_s};
        overrun_n  = overrun_r;
        done_n     = 1'b0;
        if (frm_abort) begin
            state_n  = IDLE;
            pend_v_n = 1'b0;
            words_n  = words_r;
        end else if (frm_start) begin
            state_n   = RX_HI;
            idx_n     = 5'd0;
            words_n   = 5'd0;
            overrun_n = 1'b0;
            pend_v_n  = 1'b0;
        end else begin
            if (byte_valid) begin
                case (state_r)
                    RX_HI: begin
                        eff_hi_s = byte_data;
                        eff_s    = RX_LO;
                    end
                    RX_LO: begin
                        new_v_s  = 1'b1;
                        new_hi_s = hi_r;
                        new_lo_s = byte_data;
                        eff_s    = RX_HI;
                    end
                    default: eff_s = state_r;
                endcase
            end else begin
                eff_s = state_r;
            end
            // An odd trailing byte is padded with a zero lower byte.
            if (frm_end && (eff_s == RX_HI || eff_s == RX_LO)) begin
                if (eff_s == RX_LO) begin
                    new_v_s  = 1'b1;
                    new_hi_s = eff_hi_s;
                    new_lo_s = 8'h00;
                end else begin
                    new_v_s = new_v_s;
                end
                eff_s = DRAIN;
            end else begin
                eff_s = eff_s;
            end
            if (new_v_s) begin
                if (idx_r >= 5'(NWORDS) || (pend_v_r && !fire_s)) begin
                    overrun_n = 1'b1;
                end else begin
                    pend_v_n   = 1'b1;
                    pend_hi_n  = new_hi_s;
                    pend_lo_n  = new_lo_s;
                    pend_idx_n = idx_r;
                end
                // Index saturates at NWORDS so long frames keep dropping words.
                if (idx_r < 5'(NWORDS)) begin
                    idx_n = idx_r + 5'd1;
                end else begin
                    idx_n = idx_r;
                end
            end else begin
                idx_n = idx_r;
            end
            hi_n = eff_hi_s;
            // Finish as soon as nothing remains pending so done and !busy coincide.
            if (eff_s == DRAIN && !pend_v_n) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = eff_s;
            end
        end
    end

    // State and pending-slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            hi_r       <= 8'h00;
            idx_r      <= 5'd0;
            pend_v_r   <= 1'b0;
            pend_hi_r  <= 8'h00;
            pend_lo_r  <= 8'h00;
            pend_idx_r <= 5'd0;
            words_r    <= 5'd0;
            overrun_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            hi_r       <= hi_n;
            idx_r      <= idx_n;
            pend_v_r   <= pend_v_n;
            pend_hi_r  <= pend_hi_n;
            pend_lo_r  <= pend_lo_n;
            pend_idx_r <= pend_idx_n;
            words_r    <= words_n;
            overrun_r  <= overrun_n;
            done_r     <= done_n;
        end
    end

    assign wr_hi      = pend_hi_r;
    assign wr_lo      = pend_lo_r;
    assign busy       = (state_r != IDLE);
    assign frame_done = done_r;
    assign overrun    = overrun_r;
    assign words      = words_r;
endmodule

// File: tb/tb_rx_word_sequencer.sv
// Scoreboard bench for rx_word_sequencer: a queue-based frame model predicts
// every register write and frame completion; a monitor checks what the DUT shows.
module tb_rx_word_sequencer;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frm_start = 1'b0, byte_valid = 1'b0, frm_end = 1'b0;
    logic          frm_abort = 1'b0, cpu_busy = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic [7:0]    wr_hi, wr_lo;
    logic [NW-1:0] wr_en;
    logic          busy, frame_done, overrun;
    logic [4:0]    words;

    rx_word_sequencer #(.NWORDS(NW)) dut (
        .clk(clk), .rst(rst), .frm_start(frm_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .frm_end(frm_end), .frm_abort(frm_abort),
        .cpu_busy(cpu_busy), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_en(wr_en),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .words(words)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; logic [7:0] hi; logic [7:0] lo; } wr_t;
    typedef struct { int cyc; int words; logic ovr; } done_t;
    typedef struct { int idx; logic [7:0] hi; logic [7:0] lo; } pend_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];

    // Reference model: a frame is a byte buffer plus a one-entry write slot.
    logic       m_active = 1'b0, m_drain = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_hb[$];
    pend_t      m_pend[$];
    int         m_widx = 0, m_words = 0;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic complete(input logic [7:0] hi, input logic [7:0] lo);
        pend_t p;
        if (m_widx >= NW || m_pend.size() != 0) begin
            m_ovr = 1'b1;
        end else begin
            p.idx = m_widx; p.hi = hi; p.lo = lo;
            m_pend.push_back(p);
        end
        m_widx++;
    endtask

    task automatic model_step();
        logic  fired;
        wr_t   w;
        done_t d;
        fired = (m_pend.size() != 0) && !cpu_busy;
        if (fired) begin
            w.cyc = cyc; w.idx = m_pend[0].idx; w.hi = m_pend[0].hi; w.lo = m_pend[0].lo;
            exp_wr.push_back(w);
        end
        if (rst) begin
            m_active = 1'b0; m_drain = 1'b0; m_hb.delete(); m_pend.delete();
            m_widx = 0; m_words = 0; m_ovr = 1'b0;
        end else if (frm_abort) begin
            m_active = 1'b0; m_drain = 1'b0; m_hb.delete(); m_pend.delete();
        end else if (frm_start) begin
            m_active = 1'b1; m_drain = 1'b0; m_hb.delete(); m_pend.delete();
            m_widx = 0; m_words = 0; m_ovr = 1'b0;
        end else begin
            if (fired) begin
                void'(m_pend.pop_front());
                m_words++;
            end
            if (m_active && !m_drain) begin
                if (byte_valid) begin
                    if (m_hb.size() == 0) m_hb.push_back(byte_data);
                    else complete(m_hb.pop_front(), byte_data);
                end
                if (frm_end) begin
                    if (m_hb.size() != 0) complete(m_hb.pop_front(), 8'h00);
                    m_drain = 1'b1;
                end
            end
            if (m_active && m_drain && m_pend.size() == 0) begin
                m_active = 1'b0; m_drain = 1'b0;
                d.cyc = cyc + 1; d.words = m_words; d.ovr = m_ovr;
                exp_done.push_back(d);
            end
        end
    endtask

    // One clock of stimulus, driven just after the rising edge.
    task automatic step(input logic r, input logic fs, input logic bv, input logic [7:0] bd,
                        input logic fe, input logic fa, input logic cb);
        @(posedge clk);
        #1;
        rst = r; frm_start = fs; byte_valid = bv; byte_data = bd;
        frm_end = fe; frm_abort = fa; cpu_busy = cb;
        model_step();
    endtask

    task automatic idle(input int n, input logic cb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cb);
    endtask

    task automatic put(input logic [7:0] b, input logic cb);
        step(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0, cb);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_data"}, {16'd0, wr_hi, wr_lo}, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_words"}, 32'(words), 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a done pulse.
    wr_t   mw;
    done_t md;
    always @(negedge clk) begin
        while (exp_wr.size() != 0 && exp_wr[0].cyc < cyc) begin
            mw = exp_wr.pop_front();
            chk("wr_missing", 32'(cyc), 32'(mw.cyc));
        end
        while (exp_done.size() != 0 && exp_done[0].cyc < cyc) begin
            md = exp_done.pop_front();
            chk("done_missing", 32'(cyc), 32'(md.cyc));
        end
        if (wr_en != '0) begin
            chk("wr_onehot", 32'($countones(wr_en)), 32'd1);
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                mw = exp_wr.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
                chk("wr_en", 32'(wr_en), 32'd1 << mw.idx);
                chk("wr_data", {16'd0, wr_hi, wr_lo}, {16'd0, mw.hi, mw.lo});
            end
        end
        if (frame_done) begin
            chk("done_busy", 32'(busy), 32'd0);
            if (exp_done.size() == 0) begin
                chk("done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                md = exp_done.pop_front();
                chk("done_cycle", 32'(cyc), 32'(md.cyc));
                chk("done_words", 32'(words), 32'(md.words));
                chk("done_overrun", 32'(overrun), 32'(md.ovr));
            end
        end
    end

    initial begin
        logic [7:0] bytes6[6];
        int len, stall;
        logic cb;
        bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_reset_outputs("reset");

        // Six-byte frame, no CPU contention.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        foreach (bytes6[i]) put(bytes6[i], 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        @(negedge clk);
        chk("six_words", 32'(words), 32'd3);
        chk("six_overrun", 32'(overrun), 32'd0);

        // Odd frame: trailing byte padded.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        put(8'hA1, 1'b0); put(8'hB2, 1'b0); put(8'hC3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // CPU stall with a second word lost during the stall.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        put(8'h01, 1'b1); put(8'h02, 1'b1);
        idle(3, 1'b1);
        put(8'h03, 1'b1); put(8'h04, 1'b1);
        idle(5, 1'b1);
        @(negedge clk);
        chk("stall_no_write", 32'(wr_en), 32'd0);
        chk("stall_overrun", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Twenty bytes overflow an eight-word bank.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) put(8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        @(negedge clk);
        chk("long_words", 32'(words), 32'd8);
        chk("long_overrun", 32'(overrun), 32'd1);

        // Abort while a word waits on the CPU.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        put(8'h5A, 1'b1); put(8'hA5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b0);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        idle(3, 1'b0);

        // Restart mid-frame, then reset mid-frame.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        put(8'h77, 1'b1); put(8'h88, 1'b1); put(8'h99, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        put(8'hDE, 1'b0); put(8'hAD, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        put(8'h12, 1'b1); put(8'h34, 1'b1); put(8'h56, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        check_reset_outputs("midrst");

        // Randomized frames with CPU contention, gaps, noise, aborts and restarts.
        for (int f = 0; f < 60; f++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 3) == 0));
            len = $urandom_range(0, 22);
            for (int b = 0; b < len; b++) begin
                cb = 1'($urandom_range(0, 3) == 0);
                while ($urandom_range(0, 3) == 0) idle(1, cb);
                if (b == len - 1 && $urandom_range(0, 1) == 1)
                    step(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, cb);
                else
                    put(8'($urandom), cb);
            end
            case ($urandom_range(0, 9))
                0: step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
                1: ;
                default: step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            endcase
            stall = $urandom_range(0, 6);
            for (int k = 0; k < stall; k++)
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 3) == 0), 1'b0, 1'b1);
            idle(3, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        @(negedge clk);
        #1;
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
